// File: rtl/apb_regbank_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : apb_regbank_ctrl
// Purpose  : APB slave front end for an external bank of NREG registers:
//            programmable wait states, one-hot write strobe, registered read.
// Revision : 1.0 - initial release
// ============================================================================
module apb_regbank_ctrl #(
    parameter int               DW       = 32,
    parameter int               AW       = 3,
    parameter int               NREG     = 8,
    parameter int               WAIT_CYC = 0,
    parameter logic [NREG-1:0]  RO_MASK  = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                psel_i,
    input  logic                penable_i,
    input  logic                pwrite_i,
    input  logic [AW-1:0]       paddr_i,
    input  logic [DW-1:0]       pwdata_i,
    output logic [DW-1:0]       prdata_o,
    output logic                pready_o,
    output logic                pslverr_o,
    output logic [NREG-1:0]     reg_wen_o,
    output logic [DW-1:0]       reg_wdata_o,
    input  logic [NREG*DW-1:0]  reg_rdata_i
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

    logic [1:0]      state_q,   state_d;
    logic [3:0]      cnt_q,     cnt_d;
    logic [AW-1:0]   idx_q,     idx_d;
    logic            write_q,   write_d;
    logic [DW-1:0]   wdata_q,   wdata_d;
    logic [DW-1:0]   prdata_q,  prdata_d;
    logic            pready_q,  pready_d;
    logic            pslverr_q, pslverr_d;
    logic [NREG-1:0] wen_q,     wen_d;

    logic            idx_hit;
    logic            idx_ro;
    logic [DW-1:0]   idx_rdata;
    logic [NREG-1:0] idx_onehot;
    logic            access_err;

    // Decode the latched index; an index that matches no register is out of range.
    always_comb begin
        idx_hit    = 1'b0;
        idx_ro     = 1'b0;
        idx_rdata  = '0;
        idx_onehot = '0;
        for (int i = 0; i < NREG; i++) begin
            if (idx_q == AW'(i)) begin
                idx_hit       = 1'b1;
                idx_ro        = RO_MASK[i];
                idx_rdata     = reg_rdata_i[i*DW +: DW];
                idx_onehot[i] = 1'b1;
            end
        end
    end

    assign access_err = !idx_hit || (write_q && idx_ro);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        prdata_d  = prdata_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        wen_d     = '0;

        case (state_q)
            ST_IDLE: begin
                if (psel_i && !penable_i) begin
                    idx_d   = paddr_i;
                    write_d = pwrite_i;
                    wdata_d = pwdata_i;
                    cnt_d   = WAIT_INIT;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!psel_i) begin
                    state_d = ST_IDLE;
                end else if (penable_i) begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        // Response flops load here so they are live during DONE.
                        state_d   = ST_DONE;
                        pready_d  = 1'b1;
                        pslverr_d = access_err;
                        wen_d     = (write_q && !access_err) ? idx_onehot : '0;
                        prdata_d  = (!write_q && !access_err) ? idx_rdata : '0;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            idx_q     <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            wen_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            wen_q     <= wen_d;
        end
    end

    assign prdata_o    = prdata_q;
    assign pready_o    = pready_q;
    assign pslverr_o   = pslverr_q;
    assign reg_wen_o   = wen_q;
    assign reg_wdata_o = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_regbank_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_regbank_ctrl
// Purpose  : Self-checking bench for apb_regbank_ctrl, two configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_regbank_ctrl;

    localparam logic [5:0] RO1 = 6'h01;

    logic         clk;
    logic         rst_n;
    logic         psel0, psel1, penable, pwrite;
    logic [2:0]   paddr;
    logic [31:0]  pwdata;

    logic [31:0]  prdata0, prdata1, wdata0, wdata1;
    logic         pready0, pready1, pslverr0, pslverr1;
    logic [7:0]   wen0;
    logic [5:0]   wen1;
    logic [255:0] rbus0;
    logic [191:0] rbus1;

    logic [31:0]  bank0 [8];
    logic [31:0]  bank1 [6];
    logic [31:0]  sh0   [8];
    logic [31:0]  sh1   [6];
    logic         ld;
    int           ld_i;
    logic [31:0]  ld_v0, ld_v1;

    int checks = 0;
    int errors = 0;

    apb_regbank_ctrl #(.DW(32), .AW(3), .NREG(8), .WAIT_CYC(0), .RO_MASK(8'h00)) u0 (
        .clk(clk), .rst_n(rst_n), .psel_i(psel0), .penable_i(penable), .pwrite_i(pwrite),
        .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata0), .pready_o(pready0),
        .pslverr_o(pslverr0), .reg_wen_o(wen0), .reg_wdata_o(wdata0), .reg_rdata_i(rbus0)
    );

    apb_regbank_ctrl #(.DW(32), .AW(3), .NREG(6), .WAIT_CYC(3), .RO_MASK(RO1)) u1 (
        .clk(clk), .rst_n(rst_n), .psel_i(psel1), .penable_i(penable), .pwrite_i(pwrite),
        .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata1), .pready_o(pready1),
        .pslverr_o(pslverr1), .reg_wen_o(wen1), .reg_wdata_o(wdata1), .reg_rdata_i(rbus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External register banks driven by the DUT write strobes.
    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) if (wen0[i]) bank0[i] <= wdata0;
        for (int i = 0; i < 6; i++) if (wen1[i]) bank1[i] <= wdata1;
        if (ld) begin
            bank0[ld_i] <= ld_v0;
            if (ld_i < 6) bank1[ld_i] <= ld_v1;
        end
    end

    always_comb begin
        rbus0 = '0;
        rbus1 = '0;
        for (int i = 0; i < 8; i++) rbus0[i*32 +: 32] = bank0[i];
        for (int i = 0; i < 6; i++) rbus1[i*32 +: 32] = bank1[i];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Strobe must be one-hot-or-zero and only ever accompany pready.
    always @(negedge clk) begin
        if (rst_n) begin
            check("wen0_onehot", 64'($onehot0(wen0)), 64'd1);
            check("wen0_without_ready", 64'(wen0 != 0 && !pready0), 64'd0);
            check("wen1_onehot", 64'($onehot0(wen1)), 64'd1);
            check("wen1_without_ready", 64'(wen1 != 0 && !pready1), 64'd0);
        end
    end

    task automatic set_psel(input int inst, input logic v);
        if (inst == 0) psel0 = v;
        else           psel1 = v;
    endtask

    task automatic sample(input int inst, output logic rdy, output logic slv,
                          output logic [31:0] rd, output logic [7:0] wn, output logic [31:0] wd);
        if (inst == 0) begin
            rdy = pready0; slv = pslverr0; rd = prdata0; wn = wen0; wd = wdata0;
        end else begin
            rdy = pready1; slv = pslverr1; rd = prdata1; wn = {2'b00, wen1}; wd = wdata1;
        end
    endtask

    // One complete APB transfer, started at the current negedge; returns one
    // cycle after completion with the bus idle so a following call is back-to-back.
    task automatic xfer(input int inst, input bit wr, input int idx, input logic [31:0] data);
        int          nreg, waitc, k;
        bit          ro, err;
        logic [31:0] exp_rd;
        logic [7:0]  exp_wen;
        logic        rdy, slv;
        logic [31:0] rd, wd;
        logic [7:0]  wn;
        nreg    = (inst == 0) ? 8 : 6;
        waitc   = (inst == 0) ? 0 : 3;
        ro      = (inst == 1) && (idx < 6) && RO1[idx];
        err     = (idx >= nreg) || (wr && ro);
        exp_rd  = 32'd0;
        if (!wr && !err) exp_rd = (inst == 0) ? sh0[idx] : sh1[idx];
        exp_wen = (wr && !err) ? 8'(1 << idx) : 8'd0;

        set_psel(inst, 1'b1);
        penable = 1'b0;
        pwrite  = wr;
        paddr   = 3'(idx);
        pwdata  = data;
        @(negedge clk);
        penable = 1'b1;
        pwdata  = $urandom;
        paddr   = 3'($urandom);
        pwrite  = 1'($urandom);
        k = 0;
        do begin
            @(negedge clk);
            k++;
            sample(inst, rdy, slv, rd, wn, wd);
        end while (!rdy && k < 40);
        check("latency", 64'(k), 64'(waitc + 1));
        check("pready", 64'(rdy), 64'd1);
        check("pslverr", 64'(slv), 64'(err));
        check("wen", 64'(wn), 64'(exp_wen));
        check("prdata", 64'(rd), 64'(exp_rd));
        if (wr) check("wdata", 64'(wd), 64'(data));
        if (wr && !err) begin
            if (inst == 0) sh0[idx] = data;
            else           sh1[idx] = data;
        end
        @(negedge clk);
        sample(inst, rdy, slv, rd, wn, wd);
        check("pready_single", 64'(rdy), 64'd0);
        check("wen_single", 64'(wn), 64'd0);
        set_psel(inst, 1'b0);
        penable = 1'b0;
    endtask

    initial begin
        logic        rdy, slv;
        logic [31:0] rd, wd;
        logic [7:0]  wn;
        int          inst;

        rst_n = 1'b0; psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; ld = 1'b0; ld_i = 0; ld_v0 = '0; ld_v1 = '0;

        // Seed both banks while in reset.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ld    = 1'b1;
            ld_i  = i;
            ld_v0 = $urandom;
            ld_v1 = (i == 5) ? 32'h1234_5678 : ((i == 0) ? 32'hA5A5_0001 : $urandom);
            sh0[i] = ld_v0;
            if (i < 6) sh1[i] = ld_v1;
        end
        @(negedge clk);
        ld = 1'b0;
        for (int n = 0; n < 2; n++) begin
            sample(n, rdy, slv, rd, wn, wd);
            check("rst_pready", 64'(rdy), 64'd0);
            check("rst_pslverr", 64'(slv), 64'd0);
            check("rst_prdata", 64'(rd), 64'd0);
            check("rst_wen", 64'(wn), 64'd0);
            check("rst_wdata", 64'(wd), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Zero wait states: write then back-to-back read.
        xfer(0, 1, 2, 32'hDEAD_BEEF);
        xfer(0, 0, 2, 32'h0);
        // Three wait states: read a known value.
        xfer(1, 0, 5, 32'h0);
        // Out-of-range write and read.
        xfer(1, 1, 7, 32'hCAFE_F00D);
        xfer(1, 0, 6, 32'h0);
        // Read-only register rejects a write; neighbour accepts one.
        xfer(1, 1, 0, 32'h0000_FFFF);
        xfer(1, 0, 0, 32'h0);
        xfer(1, 1, 1, 32'h1111_2222);
        xfer(1, 0, 1, 32'h0);

        // Abort in ACCESS after one wait state.
        psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd3; pwdata = 32'hBAD0_BAD0;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        psel1 = 1'b0; penable = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            check("abort_pready", 64'(pready1), 64'd0);
            check("abort_wen", 64'(wen1), 64'd0);
        end
        check("abort_bank3", 64'(bank1[3]), 64'(sh1[3]));
        xfer(1, 1, 3, 32'h3333_0003);
        xfer(1, 0, 3, 32'h0);

        // Reset during ACCESS of a write.
        psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd4; pwdata = 32'h4444_4444;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        rst_n = 1'b0; psel1 = 1'b0; penable = 1'b0;
        @(negedge clk);
        check("midrst_pready", 64'(pready1), 64'd0);
        check("midrst_pslverr", 64'(pslverr1), 64'd0);
        check("midrst_prdata", 64'(prdata1), 64'd0);
        check("midrst_wen", 64'(wen1), 64'd0);
        check("midrst_wdata", 64'(wdata1), 64'd0);
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("postrst_wen", 64'(wen1), 64'd0);
            check("postrst_pready", 64'(pready1), 64'd0);
        end
        check("postrst_bank4", 64'(bank1[4]), 64'(sh1[4]));
        xfer(1, 0, 4, 32'h0);
        xfer(1, 1, 4, 32'h5555_AAAA);
        xfer(1, 0, 4, 32'h0);

        // Randomized traffic against the model.
        for (int n = 0; n < 60; n++) begin
            inst = int'($urandom_range(0, 1));
            xfer(inst, 1'($urandom), int'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        for (int i = 0; i < 8; i++) check("final_bank0", 64'(bank0[i]), 64'(sh0[i]));
        for (int i = 0; i < 6; i++) check("final_bank1", 64'(bank1[i]), 64'(sh1[i]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
